period_detector: RTL

- Receive-side counterpart to the synth's waveform generators: consumes an 8-bit sample stream and recovers the waveform period in clock cycles.
- Uses hysteretic rising-threshold crossings, with glitch rejection, lock indication and a no-signal timeout.
- Sits on the audio sample bus. It feeds the tuner/calibration logic, which compares the measured period against the programmed `period` word.

---
 rtl/period_detector.sv | 139 +++++++++++++
 1 files changed

// File: rtl/period_detector.sv
// Recovers the period of an 8-bit sample stream from hysteretic rising
// threshold crossings, with glitch rejection, lock indication and a no-signal timeout.
module period_detector #(
   parameter logic [7:0]  THRESH_HI  = 8'd160,
   parameter logic [7:0]  THRESH_LO  = 8'd96,
   parameter logic [31:0] MIN_PERIOD = 32'd4,
   parameter logic [31:0] TOL        = 32'd2,
   parameter logic [31:0] TIMEOUT    = 32'd50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [7:0]  sample_in,
   output logic [31:0] period,
   output logic        period_valid,
   output logic        locked,
   output logic        no_signal
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      WAIT_HIGH
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] cnt;
   logic [31:0] prev;
   logic [31:0] idle_cnt;
   logic        have_ref;

   logic        armed;
   logic        candidate;
   logic        take_ref;
   logic        accept;
   logic        timeout;
   logic        idle_timeout;
   logic        stable;
   logic [31:0] cnt_inc;
   logic [31:0] idle_inc;
   logic [31:0] diff;

   assign armed    = (state == ARM) || (state == WAIT_HIGH);
   assign cnt_inc  = (cnt == '1) ? cnt : cnt + 32'd1;
   assign idle_inc = (idle_cnt == '1) ? idle_cnt : idle_cnt + 32'd1;
   // Absolute difference taken by ordering the operands so it never wraps.
   assign diff     = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
   assign stable   = (diff <= TOL) && (prev != 32'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An accepted crossing suppresses the timeout on the same edge.
   always_comb begin
      state_next = state;
      candidate  = 1'b0;
      case (state)
         IDLE: begin
            if (enable) state_next = ARM;
         end
         ARM: begin
            if (sample_in < THRESH_LO) state_next = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (sample_in >= THRESH_HI) begin
               candidate  = 1'b1;
               state_next = ARM;
            end
         end
         default: state_next = IDLE;
      endcase
      take_ref     = candidate && !have_ref;
      accept       = candidate && have_ref && (cnt >= MIN_PERIOD);
      timeout      = have_ref && (cnt >= TIMEOUT) && !accept;
      idle_timeout = armed && !have_ref && (idle_cnt >= TIMEOUT);
      if (timeout) state_next = ARM;
      if (!enable) state_next = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt          <= 32'd0;
         prev         <= 32'd0;
         idle_cnt     <= 32'd0;
         have_ref     <= 1'b0;
         period       <= 32'd0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         no_signal    <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!enable) begin
            have_ref <= 1'b0;
            cnt      <= 32'd0;
            locked   <= 1'b0;
            idle_cnt <= 32'd0;
         end else begin
            if (armed && !have_ref) begin
               idle_cnt <= idle_inc;
            end else begin
               idle_cnt <= 32'd0;
            end
            if (idle_timeout) begin
               no_signal <= 1'b1;
               period    <= 32'd0;
               locked    <= 1'b0;
            end
            // Glitches fall through to the plain count so the interval keeps growing.
            if (take_ref) begin
               cnt      <= 32'd1;
               have_ref <= 1'b1;
            end else if (accept) begin
               period       <= cnt;
               prev         <= cnt;
               cnt          <= 32'd1;
               period_valid <= 1'b1;
               no_signal    <= 1'b0;
               locked       <= stable;
            end else if (timeout) begin
               no_signal <= 1'b1;
               locked    <= 1'b0;
               period    <= 32'd0;
               have_ref  <= 1'b0;
               prev      <= 32'd0;
               cnt       <= 32'd0;
            end else if (armed && have_ref) begin
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule
